data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL take parameter ADDR_W, default 12: RAM depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL take parameter FIFO_DEPTH, default 8, a power of two >= 2: console TX FIFO depth.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: data_addr  input  32  CPU data byte address.
REQ-007 SHALL have port: data_wdata  input  32  CPU store data.
REQ-008 SHALL have port: data_wenable  input  4  byte-lane write enables; 0000 means no write.
REQ-009 SHALL have port: data_rdata  output  32  combinational read data.
REQ-010 SHALL have port: tx_data  output  8  console byte at FIFO head.
REQ-011 SHALL have port: tx_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port: tx_ready  input  1  downstream accepts tx_data.

Function
REQ-013 SHALL decode data_addr[31:16]==16'hFFFF as MMIO; all other addresses are RAM.
REQ-014 SHALL index RAM by data_addr[ADDR_W+1:2]; higher bits ignored (aliasing/wrap); data_addr[1:0] ignored.
REQ-015 SHALL read RAM combinationally, same cycle as address, full word; sign/zero extension is the CPU's job.
REQ-016 SHALL write RAM on clk rising edge, only lanes with data_wenable[i]=1 (lane i = bits 8i+7:8i).
REQ-017 SHALL return old word on data_rdata during a write cycle (write visible next cycle).
REQ-018 SHALL map MMIO offset data_addr[3:2]: 0 TXDATA, 1 STATUS, 2 CYCLE, 3 reserved (reads 0, writes ignored).
REQ-019 SHALL push data_wdata[7:0] into FIFO on a TXDATA write with data_wenable[0]=1; TXDATA reads 0.
REQ-020 SHALL read STATUS as {count zero-extended into bits 31:8, 5'b0, overflow, full, empty} (bits 2,1,0).
REQ-021 SHALL clear overflow on any STATUS write with nonzero data_wenable; other STATUS bits read-only.
REQ-022 SHALL read CYCLE as a 32-bit free-running counter, +1 per clk, wrapping 0xFFFFFFFF->0; writes ignored.
REQ-023 SHALL pop on clk edge when tx_valid && tx_ready; tx_data is the head byte, stable while tx_valid && !tx_ready.
REQ-024 SHALL accept a push when not full, or when full and a pop occurs in the same cycle.
REQ-025 SHALL drop a push when full without a same-cycle pop, and set overflow (sticky).
REQ-026 SHALL handle push+pop same cycle when empty: push accepted, no pop, tx_valid=1 next cycle.
REQ-027 SHALL assert tx_valid the cycle after the first accepted push (1-cycle latency); count updates same edge.
REQ-028 SHALL keep MMIO writes from touching RAM, and RAM-region writes from affecting MMIO.

Reset
REQ-029 SHALL on rst: FIFO empty, count=0, tx_valid=0, overflow=0, CYCLE=0, pointers=0.
REQ-030 SHALL leave RAM contents unchanged by rst; content at power-up is undefined.
REQ-031 SHALL discard FIFO contents on rst mid-transfer; tx_valid drops asynchronously.

Configuration
REQ-032 SHALL use macro DATA_MEM_CYCLE_COUNTER_EN: defined -> CYCLE register per REQ-022; undefined -> no counter flops, offset 2 reads 0 and behaves as reserved.

Structure
REQ-033 SHALL put MMIO base (16'hFFFF), offset indices, and STATUS bit positions in shared package cpu_mem_pkg.
REQ-034 SHALL implement FIFO as sub-module sync_fifo (parameter WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-035 SHALL check: store word 0xDEADBEEF @0x100 wenable 1111, then wenable 0010 data 0x00005500 -> read 0xDEAD55EF.
REQ-036 SHALL check: with ADDR_W=12, write @0x4000 -> visible at @0x0000 (wrap).
REQ-037 SHALL check: tx_ready=0, write 'A','B' to 0xFFFF0000 -> STATUS=0x00000200; then tx_ready=1 -> 'A' then 'B', then empty=1.
REQ-038 SHALL check: tx_ready=0, push 9 bytes, DEPTH 8 -> full=1, overflow=1, 9th dropped; STATUS write clears overflow only.
REQ-039 SHALL check: full FIFO, tx_ready=1 plus push same cycle -> accepted, count stays 8, no overflow.
REQ-040 SHALL check: rst asserted mid-drain -> tx_valid=0 immediately, STATUS=0x00000001; with DATA_MEM_CYCLE_COUNTER_EN, CYCLE reads 0 then increments by 1 per clk.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: MMIO window base,
// register offsets within the window, and STATUS bit layout.
package cpu_mem_pkg;

   localparam logic [15:0] MMIO_BASE = 16'hFFFF;

   typedef enum logic [1:0] {
      MMIO_TXDATA = 2'd0,
      MMIO_STATUS = 2'd1,
      MMIO_CYCLE  = 2'd2,
      MMIO_RSVD   = 2'd3
   } mmio_off_e;

   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_OVF_BIT   = 2;
   localparam int STAT_COUNT_LSB = 8;

   // Pack the STATUS word; count occupies bits 31:8, zero-extended.
   function automatic logic [31:0] status_word(input logic [23:0] cnt,
                                               input logic        ovf,
                                               input logic        full,
                                               input logic        empty);
      logic [31:0] w;
      w = '0;
      w[31:STAT_COUNT_LSB] = cnt;
      w[STAT_OVF_BIT]      = ovf;
      w[STAT_FULL_BIT]     = full;
      w[STAT_EMPTY_BIT]    = empty;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// A push into a full FIFO is accepted only when a pop happens the same cycle;
// a pop on an empty FIFO is ignored, so push+pop while empty is a pure push.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Next pointer and occupancy; pointers wrap naturally at a power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   // Control state, cleared asynchronously so tx_valid drops at once on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: word RAM with byte-lane writes and combinational
// reads, plus an MMIO window at 0xFFFF_xxxx holding a console TX FIFO,
// its STATUS register and an optional free-running CYCLE counter.
// Optional feature macro: DATA_MEM_CYCLE_COUNTER_EN (CYCLE counter present).
module data_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wenable,
   output logic [31:0] data_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]       ram [2**ADDR_W];
   logic [ADDR_W-1:0] ram_idx;
   logic              is_mmio;
   logic [1:0]        mmio_off;
   logic              ram_we;
   logic              push_req, pop_req, stat_clr;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              overflow_q, overflow_d;
   logic [31:0]       status_val;
   logic [31:0]       cycle_val;
   logic              unused_addr_bits;

   // Bits between the RAM index and the MMIO decode only alias.
   assign unused_addr_bits = ^{data_addr[15:4], data_addr[1:0]};

   assign is_mmio  = (data_addr[31:16] == MMIO_BASE);
   assign mmio_off = data_addr[3:2];
   assign ram_idx  = data_addr[ADDR_W+1:2];
   assign ram_we   = !is_mmio && (data_wenable != 4'b0000);
   assign push_req = is_mmio && (mmio_off == MMIO_TXDATA) && data_wenable[0];
   assign stat_clr = is_mmio && (mmio_off == MMIO_STATUS) && (data_wenable != 4'b0000);
   assign tx_valid = !fifo_empty;
   assign pop_req  = tx_valid && tx_ready;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_req),
      .pop_i   (pop_req),
      .wdata_i (data_wdata[7:0]),
      .rdata_o (tx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Byte-lane RAM write; the read port sees the old word until the edge.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (data_wenable[i]) ram[ram_idx][8*i +: 8] <= data_wdata[8*i +: 8];
         end
      end
   end

   // Sticky overflow: set on a dropped push, cleared by any STATUS write.
   always_comb begin
      overflow_d = overflow_q;
      if (stat_clr)
         overflow_d = 1'b0;
      else if (push_req && fifo_full && !pop_req)
         overflow_d = 1'b1;
   end

   // Overflow flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

`ifdef DATA_MEM_CYCLE_COUNTER_EN
   logic [31:0] cycle_q, cycle_d;

   assign cycle_d   = cycle_q + 32'd1;
   assign cycle_val = cycle_q;

   // Free-running cycle counter, wraps from all-ones to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cycle_q <= '0;
      else     cycle_q <= cycle_d;
   end
`else
   assign cycle_val = '0;
`endif

   assign status_val = status_word(24'(fifo_count), overflow_q, fifo_full, fifo_empty);

   // Read mux: RAM word or MMIO register, all combinational.
   always_comb begin
      data_rdata = '0;
      if (!is_mmio) begin
         data_rdata = ram[ram_idx];
      end else begin
         case (mmio_off)
            MMIO_STATUS: data_rdata = status_val;
            MMIO_CYCLE:  data_rdata = cycle_val;
            default:     data_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: RAM vector table, then FIFO sequences checked
// against a byte scoreboard and a small occupancy/overflow model.
module tb_data_mem_responder;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_wenable = '0;
   logic [31:0] data_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb[$];
   int         mcnt = 0;
   logic       movf = 1'b0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wen;
      logic [31:0] chk_addr;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vq[$];

   data_mem_responder #(.ADDR_W(12), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_wenable (data_wenable),
      .data_rdata   (data_rdata),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   // Scoreboard: a pop happens at the coming edge; compare the head byte now.
   always @(negedge clk) begin
      if (!rst && tx_valid === 1'b1 && tx_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got %02h expected no data", tx_data);
         end else begin
            check32("tx_byte", {24'b0, tx_data}, {24'b0, sb.pop_front()});
         end
      end
   end

   // Advance one clock, updating the model from the inputs driven now.
   task automatic step();
      logic mmio, push_req, pop, acc;
      mmio     = (data_addr[31:16] == 16'hFFFF);
      push_req = mmio && (data_addr[3:2] == 2'd0) && data_wenable[0];
      pop      = (mcnt > 0) && tx_ready;
      acc      = push_req && ((mcnt < DEPTH) || pop);
      if (push_req && !acc) movf = 1'b1;
      if (mmio && (data_addr[3:2] == 2'd1) && (data_wenable != 4'b0)) movf = 1'b0;
      if (acc) sb.push_back(data_wdata[7:0]);
      mcnt = mcnt + int'(acc) - int'(pop);
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
      data_addr    = addr;
      data_wenable = 4'b0;
      #1;
      check32(name, data_rdata, exp);
   endtask

   task automatic check_model_status(input string name);
      logic [31:0] exp;
      exp = {24'(mcnt), 5'b0, movf, (mcnt == DEPTH), (mcnt == 0)};
      read_chk(32'hFFFF0004, exp, name);
      check32({name, "_tx_valid"}, {31'b0, tx_valid}, {31'b0, (mcnt > 0)});
   endtask

   task automatic push_byte(input logic [7:0] b);
      data_addr    = 32'hFFFF0000;
      data_wdata   = {24'h0, b};
      data_wenable = 4'b0001;
      step();
      data_wenable = 4'b0;
   endtask

   task automatic drain(input int cycles, input string name);
      tx_ready = 1'b1;
      data_wenable = 4'b0;
      for (int i = 0; i < cycles; i++) step();
      tx_ready = 1'b0;
      check32({name, "_sb_empty"}, sb.size(), 0);
      check_model_status({name, "_status"});
   endtask

   task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                          input logic [31:0] ca, input logic [31:0] e, input string n);
      vec_t v;
      v.addr = a; v.wdata = d; v.wen = w; v.chk_addr = ca; v.exp = e; v.name = n;
      vq.push_back(v);
   endtask

   initial begin
      add_vec(32'h0000_0100, 32'hDEADBEEF, 4'b1111, 32'h0000_0100, 32'hDEADBEEF, "word_store");
      add_vec(32'h0000_0100, 32'h00005500, 4'b0010, 32'h0000_0100, 32'hDEAD55EF, "lane1_store");
      add_vec(32'h0000_4000, 32'h12345678, 4'b1111, 32'h0000_0000, 32'h12345678, "wrap_alias");
      add_vec(32'h0000_4002, 32'hAABBCCDD, 4'b1100, 32'h0000_0000, 32'hAABB5678, "upper_lanes");
      add_vec(32'h0000_0104, 32'h11223344, 4'b1111, 32'h0000_0104, 32'h11223344, "word_store2");
      add_vec(32'h0000_0104, 32'hFFFFFFFF, 4'b0000, 32'h0000_0104, 32'h11223344, "wen0_no_write");
      add_vec(32'h0000_000C, 32'h0BADF00D, 4'b1111, 32'h0000_000C, 32'h0BADF00D, "word_store3");
      add_vec(32'hFFFF_000C, 32'h55555555, 4'b1111, 32'h0000_000C, 32'h0BADF00D, "mmio_not_ram");
      add_vec(32'hFFFF_000C, 32'h00000000, 4'b0000, 32'hFFFF_000C, 32'h00000000, "reserved_reads0");
      add_vec(32'h0000_0000, 32'h00000041, 4'b0001, 32'hFFFF_0004, 32'h00000001, "ram_write_no_push");
      add_vec(32'h0000_0000, 32'h00000000, 4'b0000, 32'h0000_0000, 32'hAABB5641, "lane0_store");
      add_vec(32'hFFFF_0000, 32'h00000000, 4'b0000, 32'hFFFF_0000, 32'h00000000, "txdata_reads0");

      // Reset state.
      #2;
      check32("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      read_chk(32'hFFFF0004, 32'h00000001, "reset_status");
      read_chk(32'hFFFF0008, 32'h00000000, "reset_cycle");
      #8;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // RAM and decode vectors.
      foreach (vq[i]) begin
         data_addr    = vq[i].addr;
         data_wdata   = vq[i].wdata;
         data_wenable = vq[i].wen;
         step();
         read_chk(vq[i].chk_addr, vq[i].exp, vq[i].name);
      end

      // Old word returned during the write cycle, new word after.
      data_addr    = 32'h0000_0100;
      data_wdata   = 32'h0;
      data_wenable = 4'b1111;
      #1;
      check32("read_old_during_write", data_rdata, 32'hDEAD55EF);
      step();
      read_chk(32'h0000_0100, 32'h0, "write_visible_next");

      // Two bytes queued while blocked, then drained in order.
      push_byte(8'h41);
      push_byte(8'h42);
      read_chk(32'hFFFF0004, 32'h00000200, "status_two_bytes");
      check_model_status("two_bytes");
      drain(4, "drain_ab");
      read_chk(32'hFFFF0004, 32'h00000001, "status_empty_after_ab");

      // Overflow: ninth byte dropped, STATUS write clears only overflow.
      for (int i = 0; i < 9; i++) push_byte(8'h30 + 8'(i));
      read_chk(32'hFFFF0004, 32'h00000806, "status_overflow");
      check_model_status("overflow");
      data_addr    = 32'hFFFF0004;
      data_wdata   = 32'h0;
      data_wenable = 4'b0001;
      step();
      read_chk(32'hFFFF0004, 32'h00000802, "status_ovf_cleared");
      drain(10, "drain_overflow");

      // Full FIFO with a pop and push in the same cycle.
      for (int i = 0; i < 8; i++) push_byte(8'h60 + 8'(i));
      tx_ready = 1'b1;
      push_byte(8'h5A);
      tx_ready = 1'b0;
      read_chk(32'hFFFF0004, 32'h00000802, "full_push_pop");
      check_model_status("full_push_pop");
      drain(10, "drain_full");

      // Push and pop requested while empty: pure push.
      tx_ready = 1'b1;
      push_byte(8'h77);
      tx_ready = 1'b0;
      check32("empty_push_pop_valid", {31'b0, tx_valid}, 32'h1);
      check_model_status("empty_push_pop");
      drain(3, "drain_single");

      // Reset in the middle of a drain.
      for (int i = 0; i < 3; i++) push_byte(8'h90 + 8'(i));
      tx_ready = 1'b1;
      step();
      rst = 1'b1;
      #1;
      check32("rst_tx_valid_async", {31'b0, tx_valid}, 32'h0);
      read_chk(32'hFFFF0004, 32'h00000001, "rst_status");
      sb.delete();
      mcnt = 0;
      movf = 1'b0;
      tx_ready = 1'b0;
      #1;
      rst = 1'b0;
      read_chk(32'hFFFF0008, 32'h00000000, "cycle_after_rst");
      for (int k = 1; k <= 3; k++) begin
         step();
`ifdef DATA_MEM_CYCLE_COUNTER_EN
         read_chk(32'hFFFF0008, 32'(k), "cycle_count");
`else
         read_chk(32'hFFFF0008, 32'h0, "cycle_absent");
`endif
      end
      data_addr    = 32'hFFFF0008;
      data_wdata   = 32'h00001234;
      data_wenable = 4'b1111;
      step();
`ifdef DATA_MEM_CYCLE_COUNTER_EN
      read_chk(32'hFFFF0008, 32'd4, "cycle_write_ignored");
`else
      read_chk(32'hFFFF0008, 32'h0, "cycle_write_ignored");
`endif
      check_model_status("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
